// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: the pipeline writeback stage (P) has
// priority, while a long-latency source (L) is guaranteed service by a
// starvation counter that forces a one-cycle pipeline stall.
module wb_port_arb #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p_we,
    input  logic [4:0]      p_rd,
    input  logic [XLEN-1:0] p_data,
    input  logic            l_valid,
    input  logic [4:0]      l_rd,
    input  logic [XLEN-1:0] l_data,
    output logic            l_ready,
    output logic            pipe_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_L = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    logic p_req;
    logic l_req;
    logic grant_p;
    logic grant_l;
    logic ready_raw;

    // Writes to x0 are dropped up front so they never occupy the port.
    assign p_req = p_we & (p_rd != 5'd0);
    assign l_req = l_valid & (l_rd != 5'd0);

    // Arbitration, starvation counting and next-state selection.
    always_comb begin
        state_d    = NORMAL;
        wait_cnt_d = '0;
        grant_p    = 1'b0;
        grant_l    = 1'b0;
        ready_raw  = 1'b0;
        case (state_q)
            NORMAL: begin
                ready_raw = !p_req;
                if (p_req) begin
                    grant_p = 1'b1;
                    if (l_valid) begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d = FORCE_L;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                        end
                    end
                end else begin
                    grant_l = l_req;
                end
            end
            FORCE_L: begin
                ready_raw = 1'b1;
                grant_l   = l_req;
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    // Select the granted write; address and data hold when nothing is granted.
    always_comb begin
        rf_we_d    = grant_p | grant_l;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_p) begin
            rf_waddr_d = p_rd;
            rf_wdata_d = p_data;
        end else if (grant_l) begin
            rf_waddr_d = l_rd;
            rf_wdata_d = l_data;
        end
    end

    // State, counter and registered write port; reset discards any grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= NORMAL;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign l_ready    = rst & ready_raw;
    assign pipe_stall = (state_q == FORCE_L);
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arb.sv
// Bench for wb_port_arb: directed vectors with literal expectations plus a
// behavioural model compared against the DUT on every falling clock edge.
module tb_wb_port_arb;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            p_we = 1'b0;
    logic [4:0]      p_rd = '0;
    logic [XLEN-1:0] p_data = '0;
    logic            l_valid = 1'b0;
    logic [4:0]      l_rd = '0;
    logic [XLEN-1:0] l_data = '0;
    logic            l_ready;
    logic            pipe_stall;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    int nChecks = 0;
    int nErrors = 0;

    // Model state: whether L is being forced this cycle, how many consecutive
    // cycles L has been blocked, and the write expected on the port now.
    logic            mForce   = 1'b0;
    int              mBlocked = 0;
    logic            mWe      = 1'b0;
    logic [4:0]      mAddr    = '0;
    logic [XLEN-1:0] mData    = '0;

    wb_port_arb #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_rd(p_rd), .p_data(p_data),
        .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data),
        .l_ready(l_ready), .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait to the
    // falling edge so the caller can check that cycle's outputs.
    task automatic applyStimulus(input logic r, input logic pwe, input logic [4:0] prd,
                                 input logic [31:0] pdata, input logic lv,
                                 input logic [4:0] lrd, input logic [31:0] ldata);
        @(posedge clk);
        #1;
        rst     = r;
        p_we    = pwe;
        p_rd    = prd;
        p_data  = pdata;
        l_valid = lv;
        l_rd    = lrd;
        l_data  = ldata;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Behavioural model: P wins unless L has already waited MAX_WAIT cycles,
    // in which case the following cycle belongs to L alone.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mForce   <= 1'b0;
            mBlocked <= 0;
            mWe      <= 1'b0;
            mAddr    <= '0;
            mData    <= '0;
        end else if (mForce) begin
            mWe <= l_valid && (l_rd != 5'd0);
            if (l_valid && (l_rd != 5'd0)) begin
                mAddr <= l_rd;
                mData <= l_data;
            end
            mForce   <= 1'b0;
            mBlocked <= 0;
        end else if (p_we && (p_rd != 5'd0)) begin
            mWe   <= 1'b1;
            mAddr <= p_rd;
            mData <= p_data;
            if (!l_valid) begin
                mBlocked <= 0;
            end else if (mBlocked + 1 == MAX_WAIT) begin
                mForce   <= 1'b1;
                mBlocked <= 0;
            end else begin
                mBlocked <= mBlocked + 1;
            end
        end else begin
            mWe <= l_valid && (l_rd != 5'd0);
            if (l_valid && (l_rd != 5'd0)) begin
                mAddr <= l_rd;
                mData <= l_data;
            end
            mBlocked <= 0;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        checkOutput("model l_ready", 32'(l_ready),
                    32'(rst && (mForce || !(p_we && (p_rd != 5'd0)))));
        checkOutput("model pipe_stall", 32'(pipe_stall), 32'(mForce));
        checkOutput("model rf_we", 32'(rf_we), 32'(mWe));
        checkOutput("model rf_waddr", 32'(rf_waddr), 32'(mAddr));
        checkOutput("model rf_wdata", rf_wdata, mData);
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        logic [4:0]  sRd[7]    = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5, 5'd6};
        logic        sLv[7]    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        sReady[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        sStall[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        sWe[7]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0]  sAddr[7]  = '{5'd3, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd5};
        logic        cPwe[9]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0]  cPrd[9]   = '{5'd8, 5'd9, 5'd0, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd15};
        logic        cLv[9]    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  cLrd[9]   = '{5'd10, 5'd10, 5'd10, 5'd13, 5'd13, 5'd13, 5'd13, 5'd13, 5'd0};
        logic        cStall[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset with L asserting valid: nothing may be accepted or written.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h1111);
        checkOutput("reset l_ready", 32'(l_ready), 32'h0);
        checkOutput("reset rf_we", 32'(rf_we), 32'h0);
        checkOutput("reset pipe_stall", 32'(pipe_stall), 32'h0);
        idleCycle();
        checkOutput("post-reset rf_we", 32'(rf_we), 32'h0);

        // P only.
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        checkOutput("p-only l_ready", 32'(l_ready), 32'h0);
        idleCycle();
        checkOutput("p-only rf_we", 32'(rf_we), 32'h1);
        checkOutput("p-only rf_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("p-only rf_wdata", rf_wdata, 32'hDEADBEEF);
        idleCycle();
        checkOutput("p-only rf_we drop", 32'(rf_we), 32'h0);
        checkOutput("p-only waddr hold", 32'(rf_waddr), 32'd5);

        // x0 suppression for both requesters.
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
        checkOutput("p x0 l_ready", 32'(l_ready), 32'h1);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
        checkOutput("p x0 rf_we", 32'(rf_we), 32'h0);
        checkOutput("l x0 l_ready", 32'(l_ready), 32'h1);
        idleCycle();
        checkOutput("l x0 rf_we", 32'(rf_we), 32'h0);

        // L alone.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hA5A5A5A5);
        checkOutput("l-alone l_ready", 32'(l_ready), 32'h1);
        idleCycle();
        checkOutput("l-alone rf_we", 32'(rf_we), 32'h1);
        checkOutput("l-alone rf_waddr", 32'(rf_waddr), 32'd3);
        checkOutput("l-alone rf_wdata", rf_wdata, 32'hA5A5A5A5);

        // Starvation: P every cycle, L forced in the fifth cycle.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 1'b1, sRd[k], 32'h1000_0000 | 32'(sRd[k]),
                          sLv[k], 5'd7, 32'h12345678);
            checkOutput("starve l_ready", 32'(l_ready), 32'(sReady[k]));
            checkOutput("starve pipe_stall", 32'(pipe_stall), 32'(sStall[k]));
            checkOutput("starve rf_we", 32'(rf_we), 32'(sWe[k]));
            checkOutput("starve rf_waddr", 32'(rf_waddr), 32'(sAddr[k]));
        end
        checkOutput("starve l data", rf_wdata, 32'h10000005);
        idleCycle();
        checkOutput("starve last waddr", 32'(rf_waddr), 32'd6);
        idleCycle();
        checkOutput("starve idle rf_we", 32'(rf_we), 32'h0);

        // Counter clear: a handshake restarts the wait count from zero.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, cPwe[k], cPrd[k], 32'h2000_0000 | 32'(cPrd[k]),
                          cLv[k], cLrd[k], (k < 3) ? 32'hCAFE0001 : 32'hCAFE0002);
            checkOutput("clear pipe_stall", 32'(pipe_stall), 32'(cStall[k]));
            if (k == 2) checkOutput("clear l_ready", 32'(l_ready), 32'h1);
            if (k == 3) checkOutput("clear l waddr", 32'(rf_waddr), 32'd10);
            if (k == 8) checkOutput("clear forced wdata", rf_wdata, 32'hCAFE0002);
        end
        idleCycle();
        checkOutput("clear held p waddr", 32'(rf_waddr), 32'd15);

        // Reset asserted while in FORCE_L with L still valid.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 5'(16 + k), 32'h3000_0000, 1'b1, 5'd20, 32'hBEEF0020);
        end
        applyStimulus(1'b0, 1'b1, 5'd20, 32'h3000_0000, 1'b1, 5'd20, 32'hBEEF0020);
        checkOutput("midreset pipe_stall", 32'(pipe_stall), 32'h0);
        checkOutput("midreset rf_we", 32'(rf_we), 32'h0);
        checkOutput("midreset l_ready", 32'(l_ready), 32'h0);
        checkOutput("midreset rf_waddr", 32'(rf_waddr), 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'hBEEF0020);
        checkOutput("release l_ready", 32'(l_ready), 32'h1);
        checkOutput("release pipe_stall", 32'(pipe_stall), 32'h0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 5'(21 + k), 32'h4000_0000, 1'b1, 5'd26, 32'hBEEF0026);
            if (k == 0) checkOutput("release l write", 32'(rf_waddr), 32'd20);
            checkOutput("release count", 32'(pipe_stall), (k == 4) ? 32'h1 : 32'h0);
        end
        idleCycle();
        checkOutput("release forced waddr", 32'(rf_waddr), 32'd26);
        idleCycle();
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/wb_port_arb.md
Name: wb_port_arb

Overview:
- Arbitrates the single register-file write port between two requesters.
- Requester P is the in-order pipeline writeback stage, driven by the writeback control outputs (regWEn, selected result, rd).
- Requester L is a long-latency result source (load return or multi-cycle unit) using a valid/ready handshake.
- P has priority. A starvation counter forces a one-cycle pipeline stall so that L is always eventually granted. The granted write is registered onto the write port.

Parameters:
XLEN, 32, data width of the write port and of both requesters
MAX_WAIT, 4, consecutive blocked cycles for L before a forced grant (legal range >=1)
WCNT_W, $clog2(MAX_WAIT+1), width of the wait counter (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
p_we  in  1  pipeline writeback enable (regWEn)
p_rd  in  5  pipeline destination register
p_data  in  XLEN  pipeline writeback value (already muxed by wb_sel)
l_valid  in  1  L result valid; must stay high with stable rd/data until l_ready
l_rd  in  5  L destination register
l_data  in  XLEN  L result value
l_ready  out  1  L handshake accept (combinational)
pipe_stall  out  1  registered; while 1 the pipeline holds its WB instruction and p_* stay stable
rf_we  out  1  registered write enable to the register file
rf_waddr  out  5  registered write address
rf_wdata  out  XLEN  registered write data

Behaviour:
- Effective requests:
  - p_req = p_we & (p_rd != 0).
  - l_req = l_valid & (l_rd != 0).
  - Any write to x0 is suppressed and consumes no port cycle.
  - An L transfer with l_rd == 0 still completes its handshake (l_ready = 1 when L would otherwise be granted), but no write is made.
- State machine: two states, NORMAL and FORCE_L. pipe_stall == 1 exactly when the state is FORCE_L.
- NORMAL state:
  - Grant P if p_req.
  - Otherwise set l_ready = 1 and grant L if l_req.
  - l_ready = !p_req.
- FORCE_L state:
  - Set l_ready = 1.
  - Ignore P entirely; the pipeline is stalled, so its request is re-presented next cycle.
  - Grant L if l_req.
  - Return to NORMAL unconditionally on the next edge. If L dropped valid (protocol violation), no write is made and the FSM still returns to NORMAL.
- Wait counter (wait_cnt), NORMAL state only:
  - Increments each cycle where l_valid & p_req, i.e. L is blocked.
  - Clears on any L handshake, and on any cycle with !l_valid.
  - If L is blocked and wait_cnt == MAX_WAIT-1, the next state is FORCE_L and wait_cnt clears.
- Forced-grant timing: with P continuously requesting, L is blocked for exactly MAX_WAIT cycles. L is granted in cycle MAX_WAIT+1.
- Write port latency: a grant in cycle N produces rf_we = 1 with the granted rd/data in cycle N+1. With no grant in cycle N, rf_we = 0 in N+1; rf_waddr/rf_wdata hold their last values.
- At most one write per cycle; P and L are never both granted.
- WAW ordering between a pending L result and younger P writes is guaranteed by issue logic and is out of scope here.
- Reset (rst low, at any time including mid-FORCE_L):
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, pipe_stall = 0, wait_cnt = 0, state = NORMAL.
  - l_ready is forced to 0 while rst is low.
  - Any in-flight grant is discarded.

Test Plan:
- Reset: drive rst = 0 for one cycle while in FORCE_L with l_valid = 1 -> pipe_stall = 0, rf_we = 0, l_ready = 0 during reset. After release, the FSM is in NORMAL with wait_cnt = 0.
- P only: p_we = 1, p_rd = 5, p_data = 0xDEADBEEF for one cycle -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; then rf_we = 0.
- x0 suppression: p_we = 1, p_rd = 0 -> no rf_we. Then l_valid = 1, l_rd = 0 with P idle -> l_ready = 1, handshake completes, no rf_we.
- Starvation (MAX_WAIT = 4): P requests every cycle with distinct rd 1..6, l_valid = 1, l_rd = 7, l_data = 0x12345678 ->
  - P writes in cycles 1-4 while l_ready = 0.
  - Cycle 5: pipe_stall = 1 and l_ready = 1.
  - Cycle 6: rf_waddr = 7, rf_wdata = 0x12345678, pipe_stall = 0, and the held P request is written next.
- L alone: l_valid = 1, l_rd = 3, l_data = 0xA5A5A5A5, P idle -> l_ready = 1 in the same cycle; next cycle rf_we = 1, rf_waddr = 3, rf_wdata = 0xA5A5A5A5.
- Counter clear: block L for 2 cycles, idle P for 1 cycle (L granted), then block a new L for 4 cycles -> no FORCE_L until the 4th blocked cycle of the new request, confirming wait_cnt restarted from 0.
